mem_responder: RTL and testbench

//  Memory-side responder for the multicycle MIPS core's fetch/load/store requests.

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_mem_array.sv | 29 ++
 rtl/mem_responder.sv | 159 +++++++++++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice: FSM state encoding,
// word geometry and the wait-state counter width.
package mem_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM with write enable and a registered read port.
// Contents are never reset; the read register only changes on a read.
module mem_array #(
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**IDX_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[idx];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: valid/ready request, WAIT_CYC wait states, one-cycle
// response strobe. Define MEMRESP_ALIGN_CHK_EN to flag misaligned accesses.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        estado
);

   localparam int unsigned      IDX_W   = ADDR_W - $clog2(WORD_BYTES);
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic              mis_q, mis_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic              zero_q, zero_d;

   logic              mis_in;
   logic              acc_wr, acc_mis;
   logic [IDX_W-1:0]  acc_idx;
   logic [DATA_W-1:0] acc_wdata;
   logic              access;
   logic              ram_we, ram_re;
   logic [DATA_W-1:0] ram_rdata;

`ifdef MEMRESP_ALIGN_CHK_EN
   assign mis_in = (req_addr[1:0] != 2'b00);
`else
   logic unused_addr_lo;
   assign mis_in         = 1'b0;
   assign unused_addr_lo = ^req_addr[1:0];
`endif

   assign req_ready = rst & (state_q == IDLE);

   // With zero wait states the access happens on the accept edge, so it must
   // use the live request rather than the (not yet written) latched copy.
   always_comb begin
      if (state_q == IDLE) begin
         acc_wr    = req_write;
         acc_mis   = mis_in;
         acc_idx   = req_addr[ADDR_W-1:2];
         acc_wdata = req_wdata;
      end else begin
         acc_wr    = wr_q;
         acc_mis   = mis_q;
         acc_idx   = idx_q;
         acc_wdata = wdata_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      mis_d       = mis_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      zero_d      = zero_q;
      access      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               wr_d    = req_write;
               mis_d   = mis_in;
               idx_d   = req_addr[ADDR_W-1:2];
               wdata_d = req_wdata;
               cnt_d   = WAIT_LD;
               if (WAIT_CYC == 0) begin
                  access = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               access = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (access) begin
         state_d     = RESP;
         rsp_valid_d = 1'b1;
         rsp_err_d   = acc_mis;
         zero_d      = acc_wr | acc_mis;
      end
   end

   // Reset on the RESP-entry edge must also abort the RAM side effects.
   assign ram_we = access & rst & acc_wr & ~acc_mis;
   assign ram_re = access & rst & ~acc_wr & ~acc_mis;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         mis_q       <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         mis_q       <= mis_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         zero_q      <= zero_d;
      end
   end

   mem_array #(
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .idx   (acc_idx),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   // The read register is not reset, so stores, faults and reset force zero.
   assign rsp_rdata = zero_q ? '0 : ram_rdata;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign estado    = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: lane 0 uses WAIT_CYC=2, lane 1 WAIT_CYC=0.
// Honours MEMRESP_ALIGN_CHK_EN in its reference model.
module tb_mem_responder;

`ifdef MEMRESP_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct {
      int unsigned cyc;
      logic [31:0] rdata;
      logic        err;
      bit          load;
   } exp_t;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          done [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input int lane, input string name,
                        input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  lane, name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int unsigned WC = (g == 0) ? 2 : 0;

      logic        rst, req_valid, req_write, req_ready;
      logic        rsp_valid, rsp_err;
      logic [7:0]  req_addr;
      logic [31:0] req_wdata, rsp_rdata;
      logic [1:0]  estado;

      exp_t        exp_q [$];
      logic [31:0] mem_m [64];
      bit          acc_on = 1'b0;
      int unsigned acc_edge = 0;
      bit          live = 1'b0;
      bit          hold_on = 1'b0;
      logic [31:0] hold_val = '0;

      mem_responder #(
         .ADDR_W   (8),
         .DATA_W   (32),
         .WAIT_CYC (WC)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid),
         .req_write (req_write),
         .req_addr  (req_addr),
         .req_wdata (req_wdata),
         .req_ready (req_ready),
         .rsp_valid (rsp_valid),
         .rsp_rdata (rsp_rdata),
         .rsp_err   (rsp_err),
         .estado    (estado)
      );

      task automatic tick();
         @(posedge clk);
         #1;
      endtask

      // Issue one request; the expectation is derived from the memory model
      // at the accept edge. abort=1 resets the DUT one cycle into the wait.
      task automatic txn(input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input bit abort);
         int unsigned t;
         exp_t        e;
         logic [5:0]  idx;
         bit          mis;
         req_valid = 1'b1;
         req_write = wr;
         req_addr  = a;
         req_wdata = d;
         t = 0;
         while (req_ready !== 1'b1 && t < 40) begin
            tick();
            t++;
         end
         check(g, "accept_ready", req_ready, 1);
         if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
         end
         idx     = a[7:2];
         mis     = ALIGN && (a[1:0] != 2'b00);
         e.cyc   = cyc + 1 + WC;
         e.err   = mis;
         e.load  = !wr && !mis;
         e.rdata = (wr || mis) ? 32'h0 : mem_m[idx];
         acc_edge = cyc + 1;
         acc_on   = 1'b1;
         if (!abort) begin
            if (wr && !mis) mem_m[idx] = d;
            exp_q.push_back(e);
         end
         tick();
         if (abort) begin
            rst       = 1'b0;
            req_valid = 1'b0;
            acc_on    = 1'b0;
            tick();
            rst = 1'b1;
            tick();
            return;
         end
         for (int unsigned i = 0; i <= WC; i++) begin
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = $urandom;
            tick();
         end
         req_valid = 1'b0;
      endtask

      initial begin
         rst       = 1'b0;
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = 8'h40;
         req_wdata = 32'h5A5A5A5A;
         tick();
         live = 1'b1;
         tick();
         tick();
         check(g, "rst_estado", estado, 0);
         check(g, "rst_rdata", rsp_rdata, 0);
         check(g, "rst_err", rsp_err, 0);
         rst       = 1'b1;
         req_valid = 1'b0;
         #1;
         check(g, "rst_release_ready", req_ready, 1);
         tick();

         txn(1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
         txn(1'b0, 8'h10, 32'h0, 1'b0);
         txn(1'b1, 8'h04, 32'h12345678, 1'b0);
         txn(1'b0, 8'h04, 32'h0, 1'b0);
         txn(1'b1, 8'h20, 32'h01234567, 1'b0);
         if (WC > 0) txn(1'b1, 8'h20, 32'hAAAA5555, 1'b1);
         txn(1'b0, 8'h20, 32'h0, 1'b0);
         txn(1'b1, 8'h22, 32'hCAFEF00D, 1'b0);
         txn(1'b0, 8'h20, 32'h0, 1'b0);
         txn(1'b0, 8'h23, 32'h0, 1'b0);

         for (int unsigned w = 0; w < 64; w++) begin
            if (w != 4 && w != 1 && w != 8) txn(1'b1, 8'(w * 4), $urandom, 1'b0);
         end
         for (int unsigned n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            txn(1'($urandom), 8'($urandom), $urandom, 1'b0);
         end

         repeat (WC + 4) tick();
         check(g, "queue_drained", exp_q.size(), 0);
         done[g] = 1'b1;
      end

      always @(negedge clk) begin
         exp_t e;
         bit   exp_rdy;
         if (live) begin
            if (!rst) begin
               check(g, "rst_ready", req_ready, 0);
               check(g, "rst_rsp_valid", rsp_valid, 0);
               hold_on  = 1'b1;
               hold_val = '0;
            end else begin
               exp_rdy = !(acc_on && cyc >= acc_edge && cyc <= acc_edge + WC);
               check(g, "req_ready", req_ready, exp_rdy);
               if (rsp_valid === 1'b1) begin
                  if (exp_q.size() == 0) begin
                     check(g, "unexpected_rsp", rsp_valid, 0);
                  end else begin
                     e = exp_q.pop_front();
                     check(g, "rsp_cycle", cyc, e.cyc);
                     check(g, "rsp_rdata", rsp_rdata, e.rdata);
                     check(g, "rsp_err", rsp_err, e.err);
                     hold_on  = e.load;
                     hold_val = e.rdata;
                  end
               end else begin
                  check(g, "rsp_err_idle", rsp_err, 0);
                  if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                     check(g, "rsp_missing", rsp_valid, 1);
                     void'(exp_q.pop_front());
                  end
                  if (hold_on) check(g, "rdata_hold", rsp_rdata, hold_val);
               end
            end
         end
      end
   end

   initial begin
      int unsigned t;
      t = 0;
      while (!(done[0] && done[1]) && t < 50000) begin
         @(posedge clk);
         t++;
      end
      if (!(done[0] && done[1])) begin
         n_cmp++;
         n_bad++;
         $display("FAIL run_timeout: lanes done %0d/%0d, required 1/1", done[0], done[1]);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
